// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op codes, arbiter state type and op classification
//               helpers for the alu_arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Codes 001 and 111 have no ALU meaning.
    function automatic logic op_is_legal(input logic [2:0] op);
        return !((op == 3'b001) || (op == 3'b111));
    endfunction

    // Only ADD/SUB produce meaningful carry and overflow.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUBTRACT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu64.sv
`default_nettype none
// ============================================================================
// Module      : alu64
// Description : Combinational 64-bit ALU with carry-in, carry-out and group
//               propagate/generate outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu64
    import alu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  ctrl,
    input  logic        cIn,
    output logic [63:0] result,
    output logic        cout,
    output logic        pg,
    output logic        gg
);

    logic [63:0] b_eff;
    logic [64:0] sum;
    logic [64:0] sum_no_cin;

    // Adder datapath; subtraction is a + ~b with the carry-in supplying the +1.
    always_comb begin
        b_eff      = (ctrl == ALU_SUBTRACT) ? ~b : b;
        sum        = {1'b0, a} + {1'b0, b_eff} + {64'd0, cIn};
        sum_no_cin = {1'b0, a} + {1'b0, b_eff};
        pg         = &(a ^ b_eff);
        gg         = sum_no_cin[64];
    end

    // Result select; carry-out only reported for the adder ops.
    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (ctrl)
            ALU_PASS_B:   result = b;
            ALU_ADD,
            ALU_SUBTRACT: begin
                result = sum[63:0];
                cout   = sum[64];
            end
            ALU_AND:      result = a & b;
            ALU_OR:       result = a | b;
            ALU_XOR:      result = a ^ b;
            default:      result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin picker. Searches upward from ptr
//               (wrapping) and returns the first requester as one-hot grant
//               plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    // First requesting index at or after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one alu64 between N_REQ requesters.
//               IDLE accepts one request, EXEC runs the ALU on the latched
//               operands, RESP holds the registered result until the granted
//               requester takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*64-1:0]  req_a,
    input  logic [N_REQ*64-1:0]  req_b,
    input  logic [N_REQ*3-1:0]   req_ctrl,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [63:0]          resp_data,
    output logic                 resp_cout,
    output logic                 resp_zero,
    output logic                 resp_neg,
    output logic                 resp_ovf,
    output logic                 resp_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t    state;
    arb_state_t    state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0] idx;
    logic          accept;
    logic          resp_done;

    logic [63:0]   sel_a;
    logic [63:0]   sel_b;
    logic [2:0]    sel_ctrl;

    logic [63:0]   a_q;
    logic [63:0]   b_q;
    logic [2:0]    ctrl_q;

    logic [63:0]   alu_result;
    logic          alu_cout;
    logic          pg_unused;
    logic          gg_unused;

    logic [63:0]   b_eff;
    logic          op_legal;
    logic          op_arith;

    rr_arb #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    // Grant is only visible while idle; acceptance is any granted bit.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = |req_ready;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_resp_valid
            assign resp_valid[i] = (state == RESP) && (g == IW'(i));
        end
    endgenerate

    // resp_ready on a non-granted index is masked out by resp_valid.
    assign resp_done = |(resp_valid & resp_ready);

    // One-hot operand mux driven by the arbiter grant.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[i*64 +: 64];
                sel_b    = req_b[i*64 +: 64];
                sel_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's operands and advance the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            g      <= '0;
            ptr    <= '0;
        end else if (accept) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            ctrl_q <= sel_ctrl;
            g      <= idx;
            ptr    <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
        end
    end

    alu64 u_alu64 (
        .a      (a_q),
        .b      (b_q),
        .ctrl   (ctrl_q),
        .cIn    (ctrl_q[0]),
        .result (alu_result),
        .cout   (alu_cout),
        .pg     (pg_unused),
        .gg     (gg_unused)
    );

    // Op classification and the effective second operand for overflow.
    always_comb begin
        op_legal = op_is_legal(ctrl_q);
        op_arith = op_is_arith(ctrl_q);
        b_eff    = (ctrl_q == ALU_SUBTRACT) ? ~b_q : b_q;
    end

    // Register result and flags at the end of EXEC; held through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data <= '0;
            resp_cout <= 1'b0;
            resp_zero <= 1'b0;
            resp_neg  <= 1'b0;
            resp_ovf  <= 1'b0;
            resp_err  <= 1'b0;
        end else if (state == EXEC) begin
            if (!op_legal) begin
                resp_data <= '0;
                resp_cout <= 1'b0;
                resp_zero <= 1'b0;
                resp_neg  <= 1'b0;
                resp_ovf  <= 1'b0;
                resp_err  <= 1'b1;
            end else begin
                resp_data <= alu_result;
                resp_cout <= op_arith & alu_cout;
                resp_zero <= (alu_result == 64'd0);
                resp_neg  <= alu_result[63];
                resp_ovf  <= op_arith & (a_q[63] == b_eff[63]) &
                             (alu_result[63] != a_q[63]);
                resp_err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter (N_REQ=2) with a
//               behavioural model of the ALU results and round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [5:0]   req_ctrl;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [63:0]  resp_data;
    logic         resp_cout;
    logic         resp_zero;
    logic         resp_neg;
    logic         resp_ovf;
    logic         resp_err;

    int vecs = 0;
    int errs = 0;
    int ptr_m = 0;

    alu_arbiter #(.N_REQ(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_cout  (resp_cout),
        .resp_zero  (resp_zero),
        .resp_neg   (resp_neg),
        .resp_ovf   (resp_ovf),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Round-robin model: first valid requester at or after ptr_m.
    function automatic int pick(input logic [1:0] m);
        for (int k = 0; k < 2; k++) begin
            if (m[(ptr_m + k) % 2]) return (ptr_m + k) % 2;
        end
        return -1;
    endfunction

    // Expected {err, ovf, neg, zero, cout, data} from arithmetic definitions.
    function automatic logic [68:0] ref_resp(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] op);
        logic [64:0]        u;
        logic signed [65:0] s;
        logic [63:0]        r;
        logic               co;
        logic               ov;
        co = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                u  = {1'b0, a} + {1'b0, b};
                r  = u[63:0];
                co = u[64];
                s  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                ov = (s != $signed({{2{r[63]}}, r}));
            end
            3'b011: begin
                r  = a - b;
                co = (a >= b);
                s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                ov = (s != $signed({{2{r[63]}}, r}));
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: return {1'b1, 4'b0000, 64'd0};
        endcase
        return {1'b0, ov, r[63], (r == 64'd0), co, r};
    endfunction

    function automatic logic [68:0] observed();
        return {resp_err, resp_ovf, resp_neg, resp_zero, resp_cout, resp_data};
    endfunction

    // One full transaction: request, EXEC, RESP held for 'delay' extra cycles.
    task automatic do_txn(input logic [1:0] mask,
                          input logic [63:0] a0, input logic [63:0] b0, input logic [2:0] c0,
                          input logic [63:0] a1, input logic [63:0] b1, input logic [2:0] c1,
                          input int delay);
        int          w;
        logic [1:0]  gbit;
        logic [68:0] exp;
        @(negedge clk);
        req_valid  = mask;
        req_a      = {a1, a0};
        req_b      = {b1, b0};
        req_ctrl   = {c1, c0};
        resp_ready = 2'b00;
        #1;
        w    = pick(mask);
        gbit = (w == 0) ? 2'b01 : 2'b10;
        exp  = (w == 0) ? ref_resp(a0, b0, c0) : ref_resp(a1, b1, c1);
        vecs++;
        if (req_ready !== gbit) begin
            errs++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, gbit);
        end
        ptr_m = (w + 1) % 2;
        // EXEC: scramble inputs, which must have no effect.
        @(negedge clk);
        req_valid = 2'($urandom());
        req_a     = {rand64(), rand64()};
        req_b     = {rand64(), rand64()};
        req_ctrl  = 6'($urandom());
        #1;
        vecs++;
        if ({req_ready, resp_valid} !== 4'b0000) begin
            errs++;
            $display("FAIL exec_idle: req_ready=%b resp_valid=%b expected 00/00", req_ready, resp_valid);
        end
        for (int d = 0; d <= delay; d++) begin
            @(negedge clk);
            resp_ready = (d == delay) ? gbit : ~gbit;
            #1;
            vecs++;
            if (resp_valid !== gbit) begin
                errs++;
                $display("FAIL resp_valid: got %b expected %b (cycle %0d)", resp_valid, gbit, d);
            end
            vecs++;
            if (observed() !== exp) begin
                errs++;
                $display("FAIL resp_payload: got %h expected %h (cycle %0d)", observed(), exp, d);
            end
            vecs++;
            if (req_ready !== 2'b00) begin
                errs++;
                $display("FAIL resp_block: req_ready=%b expected 00", req_ready);
            end
        end
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if ({req_ready, resp_valid} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_hs: req_ready=%b resp_valid=%b expected 00/00", req_ready, resp_valid);
        end
        vecs++;
        if (observed() !== 69'd0) begin
            errs++;
            $display("FAIL reset_payload: got %h expected 0", observed());
        end
        @(negedge clk);
        reset_n = 1'b1;
        ptr_m   = 0;
    endtask

    task automatic test_single_add();
        do_txn(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 64'd0, 3'b000, 0);
    endtask

    task automatic test_contention();
        logic [63:0] a0, b0, a1, b1;
        logic [1:0]  exp_rdy;
        logic [68:0] exp;
        int          last;
        a0 = rand64(); b0 = rand64(); a1 = rand64(); b1 = rand64();
        last = 0;
        @(negedge clk);
        req_valid  = 2'b11;
        req_a      = {a1, a0};
        req_b      = {b1, b0};
        req_ctrl   = {3'b110, 3'b010};
        resp_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k % 3 == 0) begin
                last    = ptr_m;
                exp_rdy = (last == 0) ? 2'b01 : 2'b10;
                ptr_m   = (last + 1) % 2;
            end else begin
                exp_rdy = 2'b00;
            end
            vecs++;
            if (req_ready !== exp_rdy) begin
                errs++;
                $display("FAIL contention_grant: req_ready=%b expected %b (cycle %0d)", req_ready, exp_rdy, k);
            end
            if (k % 3 == 2) begin
                exp = (last == 0) ? ref_resp(a0, b0, 3'b010) : ref_resp(a1, b1, 3'b110);
                vecs++;
                if (resp_valid !== ((last == 0) ? 2'b01 : 2'b10) || observed() !== exp) begin
                    errs++;
                    $display("FAIL contention_resp: valid=%b data=%h expected req %0d data %h",
                             resp_valid, observed(), last, exp);
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        do_txn(2'b10, 64'd0, 64'd0, 3'b000,
               64'hCCAA_CA88_BCAA_BA88, 64'hCCAA_CA88_BCAA_BA88, 3'b011, 5);
    endtask

    task automatic test_illegal();
        do_txn(2'b01, rand64(), rand64(), 3'b111, 64'd0, 64'd0, 3'b000, 1);
        do_txn(2'b11, rand64(), rand64(), 3'b001, rand64(), rand64(), 3'b101, 0);
        do_txn(2'b10, 64'd0, 64'd0, 3'b000, 64'd5, 64'd9, 3'b011, 0);
    endtask

    task automatic test_random();
        logic [63:0] a0, b0, a1, b1;
        for (int n = 0; n < 16; n++) begin
            a0 = rand64(); b0 = rand64(); a1 = rand64(); b1 = rand64();
            if (n % 4 == 1) b0 = a0;
            if (n % 4 == 2) begin a1 = 64'h8000_0000_0000_0000; b1 = 64'hFFFF_FFFF_FFFF_FFFF; end
            do_txn(2'($urandom_range(1, 3)), a0, b0, 3'($urandom()), a1, b1, 3'($urandom()),
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid  = 2'b01;
        req_a      = {rand64(), rand64()};
        req_b      = {rand64(), rand64()};
        req_ctrl   = {3'b000, 3'b010};
        resp_ready = 2'b00;
        #1;
        vecs++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL rst_mid_grant: req_ready=%b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        vecs++;
        if (resp_valid !== 2'b01) begin
            errs++;
            $display("FAIL rst_mid_resp: resp_valid=%b expected 01", resp_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if (resp_valid !== 2'b00 || observed() !== 69'd0) begin
            errs++;
            $display("FAIL rst_mid_async: resp_valid=%b payload=%h expected 00/0", resp_valid, observed());
        end
        ptr_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(2'b11, rand64(), rand64(), 3'b100, rand64(), rand64(), 3'b101, 0);
        do_txn(2'b10, 64'd0, 64'd0, 3'b000, rand64(), rand64(), 3'b010, 0);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
